// File: rtl/stream_mux_n_to_1_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_pkg                                                          |
// | Shared types and constants for the N-to-1 stream multiplexer.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mux_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_e;

endpackage
`default_nettype wire

// File: rtl/stream_mux_n_to_1_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stream_mux_n_to_1_if                                             |
// | N input streams and one output stream with valid/ready handshake.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface stream_mux_n_to_1_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_ready;

  // master: producers plus consumer around the mux; slave: the mux itself
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface
`default_nettype wire

// File: rtl/stream_mux_n_to_1_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick                                                          |
// | Combinational rotating-priority picker: first requester after    |
// | 'last', wrapping modulo N.                                       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_pick #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  output logic          gnt_vld,
  output logic [SW-1:0] gnt_idx
);

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'((int'(last) + k) % N);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_mux_n_to_1.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stream_mux_n_to_1                                                |
// | N-to-1 stream mux, explicit-select or round-robin, one register  |
// | stage. Optional STREAM_MUX_CNT_EN adds a 16-bit xfer_cnt port.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module stream_mux_n_to_1
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  stream_mux_n_to_1_if.slave bus
`ifdef STREAM_MUX_CNT_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);

  mux_mode_e     mode_e;
  logic          load;
  logic          rr_vld;
  logic [SW-1:0] rr_idx;
  logic          win_vld;
  logic [SW-1:0] win_idx;
  logic [W-1:0]  win_data;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic [SW-1:0] rr_last_q,   rr_last_d;

  assign mode_e = mux_mode_e'(mode);
  assign load   = !out_valid_q || bus.out_ready;

  rr_pick #(.N(N)) u_rr_pick (
    .req     (bus.in_valid),
    .last    (rr_last_q),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  always_comb begin
    win_vld = 1'b0;
    win_idx = sel;
    if (mode_e == MODE_RR) begin
      win_vld = rr_vld;
      win_idx = rr_idx;
    end else if (int'(sel) < N) begin
      win_vld = bus.in_valid[sel];
    end
  end

  assign win_data     = bus.in_data[win_idx*W +: W];
  assign bus.in_ready = (!rst && load && win_vld) ? (N'(1) << win_idx) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_last_d   = rr_last_q;
    if (load) begin
      out_valid_d = win_vld;
      if (win_vld) begin
        out_data_d = win_data;
        out_ch_d   = win_idx;
        if (mode_e == MODE_RR) begin
          rr_last_d = win_idx;
        end
      end
    end
  end

  // rr_last resets to N-1 so channel 0 is the first round-robin grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_last_q   <= SW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

`ifdef STREAM_MUX_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_n_to_1.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_stream_mux_n_to_1                                             |
// | Directed bench with a per-cycle reference model for the mux.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_stream_mux_n_to_1;
  import mux_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          mode = 1'b0;
  logic [SW-1:0] sel  = '0;

  int n_checks = 0;
  int n_fail   = 0;

  stream_mux_n_to_1_if #(.N(N), .W(W)) bus ();

`ifdef STREAM_MUX_CNT_EN
  logic [CNT_W-1:0] xfer_cnt;
`endif

  stream_mux_n_to_1 #(.N(N), .W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .sel  (sel),
    .bus  (bus)
`ifdef STREAM_MUX_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the output register contents as the rules dictate.
  logic           m_ok    = 1'b0;
  logic           m_valid = 1'b0;
  logic [W-1:0]   m_data  = '0;
  int             m_ch    = 0;
  int             m_last  = N - 1;
  int unsigned    m_cnt   = 0;

  function automatic int model_winner(input logic md, input int s, input logic [N-1:0] v, input int last);
    if (!md) return (s < N && v[s]) ? s : -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    w = model_winner(mode, int'(sel), bus.in_valid, m_last);
    if (!rst && (!m_valid || bus.out_ready) && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ok    <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ch    <= 0;
      m_last  <= N - 1;
      m_cnt   <= 0;
    end else begin
      if (m_valid && bus.out_ready) m_cnt <= (m_cnt + 1) % 65536;
      if (!m_valid || bus.out_ready) begin
        if (model_winner(mode, int'(sel), bus.in_valid, m_last) >= 0) begin
          m_valid <= 1'b1;
          m_data  <= bus.in_data[model_winner(mode, int'(sel), bus.in_valid, m_last)*W +: W];
          m_ch    <= model_winner(mode, int'(sel), bus.in_valid, m_last);
          if (mode) m_last <= model_winner(mode, int'(sel), bus.in_valid, m_last);
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("model in_ready",  64'(bus.in_ready),  64'(exp_ready()));
      check("model out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("model out_data",  64'(bus.out_data),  64'(m_data));
      check("model out_ch",    64'(bus.out_ch),    64'(m_ch));
`ifdef STREAM_MUX_CNT_EN
      check("model xfer_cnt",  64'(xfer_cnt),      64'(m_cnt));
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3);
    bus.in_data = {d3, d2, d1, d0};
  endtask

  initial begin
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);

    // reset held for two cycles with all channels valid
    tick();
    check("rst in_ready", 64'(bus.in_ready), 64'h0);
    tick();
    check("rst out_valid", 64'(bus.out_valid), 64'h0);
    check("rst out_data",  64'(bus.out_data),  64'h0);
    check("rst out_ch",    64'(bus.out_ch),    64'h0);
    check("rst in_ready2", 64'(bus.in_ready),  64'h0);

    // explicit select
    rst  = 1'b0;
    mode = 1'b0;
    sel  = 2'd2;
    bus.in_valid = 4'b0100;
    set_data(8'h10, 8'h11, 8'hA5, 8'h13);
    #1;
    check("sel in_ready", 64'(bus.in_ready), 64'h4);
    tick();
    check("sel out_valid", 64'(bus.out_valid), 64'h1);
    check("sel out_data",  64'(bus.out_data),  64'hA5);
    check("sel out_ch",    64'(bus.out_ch),    64'h2);
    sel = 2'd3;
    #1;
    check("sel3 in_ready", 64'(bus.in_ready), 64'h0);
    tick();
    check("sel3 out_valid", 64'(bus.out_valid), 64'h0);

    // round-robin fairness
    mode = 1'b1;
    bus.in_valid = 4'b1111;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    #1;
    check("rr first in_ready", 64'(bus.in_ready), 64'h1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr out_ch",   64'(bus.out_ch),   64'(k % 4));
      check("rr out_data", 64'(bus.out_data), 64'(8'h10 + k % 4));
      check("rr onehot",   64'($onehot(bus.in_ready)), 64'h1);
    end

    // wrap and skip after a grant to ch3
    bus.in_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("skip in_ready[2:1]", 64'(bus.in_ready[2:1]), 64'h0);
      tick();
      check("skip out_ch", 64'(bus.out_ch), (k % 2 == 0) ? 64'h0 : 64'h3);
    end

    // backpressure: ch3 word held
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp in_ready", 64'(bus.in_ready), 64'h0);
      tick();
      check("bp out_valid", 64'(bus.out_valid), 64'h1);
      check("bp out_ch",    64'(bus.out_ch),    64'h3);
      check("bp out_data",  64'(bus.out_data),  64'h13);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp release in_ready", 64'(bus.in_ready), 64'h1);
    tick();
    check("bp reload out_ch",   64'(bus.out_ch),   64'h0);
    check("bp reload out_data", 64'(bus.out_data), 64'h10);

    // reset mid-transfer discards the held word
    rst = 1'b1;
    #1;
    check("midrst in_ready", 64'(bus.in_ready), 64'h0);
    tick();
    check("midrst out_valid", 64'(bus.out_valid), 64'h0);
    check("midrst out_data",  64'(bus.out_data),  64'h0);
    rst = 1'b0;

    // mode 0 grant leaves round-robin pointer untouched
    mode = 1'b0;
    sel  = 2'd1;
    tick();
    check("m0 out_ch", 64'(bus.out_ch), 64'h1);
    mode = 1'b1;
    tick();
    check("resume out_ch", 64'(bus.out_ch), 64'h0);
    bus.in_valid = 4'b0000;
    tick();
    check("idle out_valid", 64'(bus.out_valid), 64'h0);
    check("idle out_ch",    64'(bus.out_ch),    64'h0);

`ifdef STREAM_MUX_CNT_EN
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    mode = 1'b0;
    sel  = 2'd0;
    bus.in_valid = 4'b0001;
    repeat (5) tick();
    bus.in_valid = 4'b0000;
    tick();
    check("cnt five", 64'(xfer_cnt), 64'd5);
    rst = 1'b1;
    tick();
    check("cnt reset", 64'(xfer_cnt), 64'd0);
    rst = 1'b0;
    bus.in_valid = 4'b0001;
    repeat (65536) tick();
    check("cnt max", 64'(xfer_cnt), 64'd65535);
    tick();
    check("cnt wrap", 64'(xfer_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
